// File: rtl/fmult_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fmult_seq_pkg
// Purpose  : Shared widths, product indices and FSM encoding for fmult_seq.
// Revision : 1.0
// ============================================================================
package fmult_seq_pkg;

  localparam int EXP_W  = 4;
  localparam int MANT_W = 6;
  localparam int FLT_W  = 11;
  localparam int COEF_W = 16;
  localparam int NPROD  = 8;
  localparam int CNT_W  = 3;

  localparam logic [CNT_W-1:0] IDX_WA1 = 3'd0;
  localparam logic [CNT_W-1:0] IDX_WA2 = 3'd1;
  localparam logic [CNT_W-1:0] IDX_WB1 = 3'd2;
  localparam logic [CNT_W-1:0] IDX_WB2 = 3'd3;
  localparam logic [CNT_W-1:0] IDX_WB3 = 3'd4;
  localparam logic [CNT_W-1:0] IDX_WB4 = 3'd5;
  localparam logic [CNT_W-1:0] IDX_WB5 = 3'd6;
  localparam logic [CNT_W-1:0] IDX_WB6 = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/fmult_core.sv
`default_nettype none
// ============================================================================
// Module   : fmult_core
// Purpose  : Combinational G.726 FMULT: 16-bit coefficient times float sample.
// Revision : 1.0
// ============================================================================
module fmult_core
  import fmult_seq_pkg::*;
(
  input  logic [COEF_W-1:0] an,
  input  logic [FLT_W-1:0]  srn,
  output logic [COEF_W-1:0] wn
);

  logic [12:0]       w_anmag;
  logic [EXP_W-1:0]  w_anexp;
  logic [MANT_W-1:0] w_anmant;
  logic              w_ws;
  logic [4:0]        w_wexp;
  logic [7:0]        w_wmant;
  logic [16:0]       w_base;
  logic [14:0]       w_wmag;

  // Magnitude drops the two LSBs; the 13-bit mask folds 0x8000 to zero.
  assign w_anmag = 13'((an[15] ? (16'd0 - an) : an) >> 2);

  always_comb begin
    w_anexp = '0;
    for (int i = 0; i < 13; i++) begin
      if (w_anmag[i]) w_anexp = EXP_W'(i + 1);
    end
  end

  assign w_anmant = (w_anmag == 13'd0) ? 6'd32
                                       : 6'({w_anmag, 6'b0} >> w_anexp);
  assign w_ws     = an[15] ^ srn[10];
  assign w_wexp   = {1'b0, w_anexp} + {1'b0, srn[9:6]};
  assign w_wmant  = 8'(({6'b0, srn[5:0]} * {6'b0, w_anmant} + 12'd48) >> 4);
  assign w_base   = {2'b0, w_wmant, 7'b0};

  // Only WEXP 27/28 shift left; the excess bits wrap away at 15 bits.
  assign w_wmag = 15'((w_wexp <= 5'd26) ? (w_base >> (5'd26 - w_wexp))
                                        : (w_base << (w_wexp - 5'd26)));

  assign wn = w_ws ? (16'd0 - {1'b0, w_wmag}) : {1'b0, w_wmag};

endmodule
`default_nettype wire

// File: rtl/fmult_seq.sv
`default_nettype none
// ============================================================================
// Module   : fmult_seq
// Purpose  : Eight G.726 FMULT products over one shared core, one per cycle.
// Revision : 1.0
// ============================================================================
module fmult_seq
  import fmult_seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [COEF_W-1:0] A1, A2,
  input  logic [COEF_W-1:0] B1, B2, B3, B4, B5, B6,
  input  logic [FLT_W-1:0]  SR1, SR2,
  input  logic [FLT_W-1:0]  DQ1, DQ2, DQ3, DQ4, DQ5, DQ6,
  output logic              busy,
  output logic              done,
  output logic [COEF_W-1:0] WA1, WA2,
  output logic [COEF_W-1:0] WB1, WB2, WB3, WB4, WB5, WB6
);

  state_t             r_state, w_state_nxt;
  logic               w_load;
  logic [CNT_W-1:0]   r_cnt;
  logic [COEF_W-1:0]  w_coef_in [NPROD];
  logic [FLT_W-1:0]   w_flt_in  [NPROD];
  logic [COEF_W-1:0]  r_coef    [NPROD];
  logic [FLT_W-1:0]   r_flt     [NPROD];
  logic [COEF_W-1:0]  r_w       [NPROD];
  logic [COEF_W-1:0]  w_prod;

  assign w_coef_in = '{A1, A2, B1, B2, B3, B4, B5, B6};
  assign w_flt_in  = '{SR1, SR2, DQ1, DQ2, DQ3, DQ4, DQ5, DQ6};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: if (start) begin
        w_state_nxt = ST_RUN;
        w_load      = 1'b1;
      end
      ST_RUN:  if (r_cnt == IDX_WB6) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  fmult_core u_core (
    .an  (r_coef[r_cnt]),
    .srn (r_flt[r_cnt]),
    .wn  (w_prod)
  );

  // Result for index r_cnt lands in its own slot; other slots hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      for (int i = 0; i < NPROD; i++) begin
        r_coef[i] <= '0;
        r_flt[i]  <= '0;
        r_w[i]    <= '0;
      end
    end else if (w_load) begin
      r_cnt  <= '0;
      r_coef <= w_coef_in;
      r_flt  <= w_flt_in;
    end else if (r_state == ST_RUN) begin
      r_cnt        <= r_cnt + 1'b1;
      r_w[r_cnt]   <= w_prod;
    end
  end

  assign busy = (r_state != ST_IDLE);
  assign done = (r_state == ST_DONE);

  assign WA1 = r_w[IDX_WA1];
  assign WA2 = r_w[IDX_WA2];
  assign WB1 = r_w[IDX_WB1];
  assign WB2 = r_w[IDX_WB2];
  assign WB3 = r_w[IDX_WB3];
  assign WB4 = r_w[IDX_WB4];
  assign WB5 = r_w[IDX_WB5];
  assign WB6 = r_w[IDX_WB6];

endmodule
`default_nettype wire

// File: tb/tb_fmult_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_fmult_seq
// Purpose  : Randomized and directed bench for fmult_seq with arithmetic model.
// Revision : 1.0
// ============================================================================
module tb_fmult_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] coef [8];
  logic [10:0] flt  [8];
  logic [15:0] wout [8];
  logic        busy, done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model state: one outstanding run at most.
  logic        run_valid = 1'b0;
  int          run_t     = 0;
  logic [15:0] exp_next [8];
  logic [15:0] exp_out  [8] = '{default: 16'h0000};
  string       names    [8] = '{"WA1", "WA2", "WB1", "WB2", "WB3", "WB4", "WB5", "WB6"};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fmult_seq dut (
    .clk   (clk),     .reset (reset),   .start (start),
    .A1    (coef[0]), .A2    (coef[1]),
    .B1    (coef[2]), .B2    (coef[3]), .B3 (coef[4]),
    .B4    (coef[5]), .B5    (coef[6]), .B6 (coef[7]),
    .SR1   (flt[0]),  .SR2   (flt[1]),
    .DQ1   (flt[2]),  .DQ2   (flt[3]),  .DQ3 (flt[4]),
    .DQ4   (flt[5]),  .DQ5   (flt[6]),  .DQ6 (flt[7]),
    .busy  (busy),    .done  (done),
    .WA1   (wout[0]), .WA2   (wout[1]),
    .WB1   (wout[2]), .WB2   (wout[3]), .WB3 (wout[4]),
    .WB4   (wout[5]), .WB5   (wout[6]), .WB6 (wout[7])
  );

  // Plain integer arithmetic straight from the FMULT definition.
  function automatic logic [15:0] fmult_ref(input logic [15:0] an, input logic [10:0] sr);
    int a, mag, e, mant, wexp, wmant, wmag, res;
    a    = $signed(an);
    mag  = ((a < 0) ? -a : a) / 4;
    mag  = mag % 8192;
    e    = 0;
    while ((mag >> e) != 0) e++;
    mant = (mag == 0) ? 32 : (mag * 64) / (1 << e);
    wexp = e + int'(sr[9:6]);
    wmant = (int'(sr[5:0]) * mant + 48) / 16;
    if (wexp <= 26) wmag = (wmant * 128) / (1 << (26 - wexp));
    else            wmag = (wmant * 128) * (1 << (wexp - 26));
    wmag = wmag % 32768;
    res  = (an[15] ^ sr[10]) ? -wmag : wmag;
    return res[15:0];
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_ops();
    for (int i = 0; i < 8; i++) begin
      coef[i] = 16'($urandom);
      flt[i]  = 11'($urandom);
    end
  endtask

  // Drive start for one cycle; the model accepts it only when the block is idle.
  task automatic pulse_start();
    start = 1'b1;
    if (!run_valid || cyc >= run_t + 10) begin
      for (int i = 0; i < 8; i++) exp_next[i] = fmult_ref(coef[i], flt[i]);
      run_t     = cyc;
      run_valid = 1'b1;
    end
    tick();
    start = 1'b0;
  endtask

  task automatic do_reset(input int n);
    reset     = 1'b1;
    run_valid = 1'b0;
    for (int i = 0; i < 8; i++) exp_out[i] = 16'h0000;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  // Compare process: control outputs every cycle, results whenever not mid-run.
  always @(negedge clk) begin
    logic exp_busy, exp_done, in_run;
    exp_done = run_valid && (cyc == run_t + 9);
    exp_busy = run_valid && (cyc > run_t) && (cyc <= run_t + 9);
    in_run   = run_valid && (cyc > run_t) && (cyc <= run_t + 8);
    if (exp_done) for (int i = 0; i < 8; i++) exp_out[i] = exp_next[i];
    chk("busy", {15'd0, busy}, {15'd0, exp_busy});
    chk("done", {15'd0, done}, {15'd0, exp_done});
    if (!in_run) for (int i = 0; i < 8; i++) chk(names[i], wout[i], exp_out[i]);
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      coef[i] = 16'h0000;
      flt[i]  = 11'h000;
    end

    // Hand-computed values that pin the model itself.
    chk("model_pos",  fmult_ref(16'h4000, 11'h2A0), 16'h0430);
    chk("model_neg",  fmult_ref(16'hC000, 11'h2A0), 16'hFBD0);
    chk("model_sr_s", fmult_ref(16'h4000, 11'h6A0), 16'hFBD0);
    chk("model_wrap", fmult_ref(16'h7FFF, 11'h3FF), 16'h7600);
    chk("model_zero", fmult_ref(16'h0000, 11'h020), 16'h0000);

    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Zero coefficients.
    for (int i = 0; i < 8; i++) begin
      coef[i] = 16'h0000;
      flt[i]  = 11'h020;
    end
    pulse_start();
    randomize_ops();
    repeat (9) tick();
    for (int i = 0; i < 8; i++) chk({"zero_", names[i]}, wout[i], 16'h0000);

    // Sign handling and overflow wrap, with a stray start at T+3.
    randomize_ops();
    coef[0] = 16'h4000; flt[0] = 11'h2A0;
    coef[1] = 16'hC000; flt[1] = 11'h2A0;
    coef[2] = 16'h7FFF; flt[2] = 11'h3FF;
    pulse_start();
    tick();
    tick();
    randomize_ops();
    pulse_start();
    repeat (6) tick();
    chk("sign_WA1", wout[0], 16'h0430);
    chk("sign_WA2", wout[1], 16'hFBD0);
    chk("wrap_WB1", wout[2], 16'h7600);

    // Back-to-back start at T+10 with new operands.
    coef[0] = 16'h4000; flt[0] = 11'h6A0;
    pulse_start();
    randomize_ops();
    repeat (9) tick();
    chk("b2b_WA1", wout[0], 16'hFBD0);

    // Reset at T+4 of a run, then watch for a stray done.
    randomize_ops();
    pulse_start();
    repeat (3) tick();
    do_reset(2);
    repeat (12) tick();
    chk("rst_WA1", wout[0], 16'h0000);
    chk("rst_busy", {15'd0, busy}, 16'h0000);

    // Random traffic: operands change every cycle, starts arrive at random.
    for (int c = 0; c < 3000; c++) begin
      randomize_ops();
      if ($urandom_range(0, 599) == 0) do_reset(1);
      else if ($urandom_range(0, 3) == 0) pulse_start();
      else tick();
    end

    repeat (12) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
